// File: rtl/alu_pipe.sv
// Pipelined integer ALU/compare unit with valid/ready handshake and bubble-collapsing stages.
// Optional macro ALU_SHADD_EN adds shadd_i[1:0] for Zba shift-and-add on ADD_SUB.
module alu_pipe #(
    parameter int unsigned XLEN               = 64,
    parameter int unsigned LATENCY            = 2,
    parameter int unsigned PHY_REG_ADDR_WIDTH = 6,
    parameter int unsigned ROB_INDEX_WIDTH    = 5
) (
    input  logic                               clk,
    input  logic                               rstn,
`ifdef ALU_SHADD_EN
    input  logic [1:0]                         shadd_i,
`endif
    input  logic                               flush,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [XLEN-1:0]                    alu_input_a,
    input  logic [XLEN-1:0]                    alu_input_b,
    input  logic [XLEN-1:0]                    cmp_input_a,
    input  logic [XLEN-1:0]                    cmp_input_b,
    input  logic [2:0]                         alu_function_select,
    input  logic                               function_modifier,
    input  logic                               half,
    input  logic [2:0]                         cmp_function_select,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]      rd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]         rob_index_i,
    output logic                               done_o,
    input  logic                               ready_i,
    output logic [XLEN-1:0]                    alu_result,
    output logic                               cmp_result,
    output logic [PHY_REG_ADDR_WIDTH-1:0]      rd_addr_o,
    output logic [ROB_INDEX_WIDTH-1:0]         rob_index_o,
    output logic [$clog2(LATENCY+1)-1:0]       occupancy_o
);

    localparam int unsigned OW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {
        OP_ADD_SUB = 3'd0,
        OP_SLL     = 3'd1,
        OP_SLT     = 3'd2,
        OP_SLTU    = 3'd3,
        OP_XOR     = 3'd4,
        OP_SRL_SRA = 3'd5,
        OP_OR      = 3'd6,
        OP_AND_CLR = 3'd7
    } alu_op_e;

    logic                    w_op;
    logic [5:0]              shamt;
    logic [XLEN-1:0]         add_a;
    logic [31:0]             a32, b32, r32;
    logic                    use_r32;
    logic [XLEN-1:0]         res_d;
    logic                    cmp_raw, cmp_d;

    assign w_op  = (XLEN == 64) && half;
    assign shamt = ((XLEN == 64) && !half) ? alu_input_b[5:0] : {1'b0, alu_input_b[4:0]};
    assign a32   = alu_input_a[31:0];
    assign b32   = alu_input_b[31:0];

`ifdef ALU_SHADD_EN
    assign add_a = (!function_modifier && !w_op) ? (alu_input_a << shadd_i) : alu_input_a;
`else
    assign add_a = alu_input_a;
`endif

    always_comb begin
        res_d   = '0;
        r32     = '0;
        use_r32 = 1'b0;
        unique case (alu_op_e'(alu_function_select))
            OP_ADD_SUB: begin
                use_r32 = w_op;
                r32     = function_modifier ? (a32 - b32) : (a32 + b32);
                res_d   = function_modifier ? (alu_input_a - alu_input_b) : (add_a + alu_input_b);
            end
            OP_SLL: begin
                use_r32 = w_op;
                r32     = a32 << shamt[4:0];
                res_d   = alu_input_a << shamt;
            end
            OP_SLT:  res_d = XLEN'($signed(alu_input_a) < $signed(alu_input_b));
            OP_SLTU: res_d = XLEN'(alu_input_a < alu_input_b);
            OP_XOR:  res_d = alu_input_a ^ alu_input_b;
            OP_SRL_SRA: begin
                use_r32 = w_op;
                r32     = function_modifier ? 32'($signed(a32) >>> shamt[4:0]) : (a32 >> shamt[4:0]);
                res_d   = function_modifier ? XLEN'($signed(alu_input_a) >>> shamt)
                                            : (alu_input_a >> shamt);
            end
            OP_OR:      res_d = alu_input_a | alu_input_b;
            OP_AND_CLR: res_d = function_modifier ? (~alu_input_a & alu_input_b)
                                                  : (alu_input_a & alu_input_b);
            default:    res_d = '0;
        endcase
        if (use_r32) res_d = XLEN'($signed(r32));
    end

    always_comb begin
        if (cmp_function_select[2])
            cmp_raw = cmp_function_select[1] ? (cmp_input_a < cmp_input_b)
                                             : ($signed(cmp_input_a) < $signed(cmp_input_b));
        else
            cmp_raw = (cmp_input_a == cmp_input_b);
        cmp_d = cmp_raw ^ cmp_function_select[0];
    end

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0]            load;
    logic [XLEN-1:0]               res_q [LATENCY];
    logic                          cmp_q [LATENCY];
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_q  [LATENCY];
    logic [ROB_INDEX_WIDTH-1:0]    rob_q [LATENCY];
    logic [OW-1:0]                 occ_q;
    logic                          accept, out_hs;

    // Stage k may load iff some stage from k to the end is empty or the output drains;
    // this closed form avoids a combinational chain through neighbouring advance signals.
    always_comb begin
        logic full;
        load = '0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            full = 1'b1;
            for (int unsigned j = k; j < LATENCY; j++) full = full & vld_q[j];
            load[k] = ready_i | ~full;
        end
    end

    assign ready_o = load[0];
    assign accept  = valid_i & ready_o;
    assign out_hs  = vld_q[LATENCY-1] & ready_i;

    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) begin
                res_q[k] <= '0;
                cmp_q[k] <= 1'b0;
                rd_q[k]  <= '0;
                rob_q[k] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            for (int unsigned k = LATENCY - 1; k >= 1; k--) begin
                if (load[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        res_q[k] <= res_q[k-1];
                        cmp_q[k] <= cmp_q[k-1];
                        rd_q[k]  <= rd_q[k-1];
                        rob_q[k] <= rob_q[k-1];
                    end
                end
            end
            if (load[0]) begin
                vld_q[0] <= valid_i;
                if (valid_i) begin
                    res_q[0] <= res_d;
                    cmp_q[0] <= cmp_d;
                    rd_q[0]  <= rd_addr_i;
                    rob_q[0] <= rob_index_i;
                end
            end
            occ_q <= occ_q + OW'(accept) - OW'(out_hs);
        end
    end

    assign done_o      = vld_q[LATENCY-1];
    assign alu_result  = res_q[LATENCY-1];
    assign cmp_result  = cmp_q[LATENCY-1];
    assign rd_addr_o   = rd_q[LATENCY-1];
    assign rob_index_o = rob_q[LATENCY-1];
    assign occupancy_o = occ_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU/compare execution unit for the out-of-order backend. It sits between the integer issue queue and the writeback/ROB-complete path. It accepts one micro-op per cycle under a valid/ready handshake and carries it through `LATENCY` bubble-collapsing register stages. Each slot carries its destination tag and ROB index. `flush` squashes every in-flight slot.

## Interface
- `XLEN`, 64: datapath width; legal values 32 or 64.
- `LATENCY`, 2: register stages from accept to output; legal 1..4.
- `PHY_REG_ADDR_WIDTH`, 6: physical destination tag width.
- `ROB_INDEX_WIDTH`, 5: ROB index width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset, synchronous, active-high (1 = reset).
- `flush`  in  1  synchronous squash of all in-flight ops.
- `valid_i`  in  1  op present.
- `ready_o`  out  1  unit accepts the op this cycle.
- `alu_input_a`, `alu_input_b`  in  XLEN  ALU operands.
- `cmp_input_a`, `cmp_input_b`  in  XLEN  compare operands.
- `alu_function_select`  in  3  0 ADD_SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL_SRA, 6 OR, 7 AND_CLR.
- `function_modifier`  in  1  SUB / SRA / ANDN (`~a & b`).
- `half`  in  1  32-bit W-op, sign-extended result; ignored when XLEN=32.
- `cmp_function_select`  in  3  bit2 less (else equal), bit1 unsigned, bit0 negate.
- `rd_addr_i`  in  PHY_REG_ADDR_WIDTH;  `rob_index_i`  in  ROB_INDEX_WIDTH.
- `done_o`  out  1  result valid at output.
- `ready_i`  in  1  downstream accepts result.
- `alu_result`  out  XLEN;  `cmp_result`  out  1.
- `rd_addr_o`  out  PHY_REG_ADDR_WIDTH;  `rob_index_o`  out  ROB_INDEX_WIDTH.
- `occupancy_o`  out  $clog2(LATENCY+1)  number of valid slots.

## Operation
- Results are computed combinationally at accept and written into stage 0. Stages 1..LATENCY-1 only move data.
- Shift amount is `b[5:0]` when XLEN=64 and not half; otherwise `b[4:0]`.
- W-ops (half=1) operate on `a[31:0]`/`b[31:0]`. The 32-bit result is sign-extended from bit 31; this applies to ADD_SUB, SLL and SRL_SRA only.
- SLT/SLTU produce the compare result zero-extended to XLEN.
- Compare: `less` selects signed or unsigned `<`, as chosen by bit1; otherwise equality. The negate bit inverts the final result.
- Each stage holds a valid bit plus its payload: result, cmp, rd, rob.
- Stage k loads from stage k-1 when stage k is empty or is itself advancing.
- The last stage advances when `ready_i`=1.
- `ready_o` = ~stage0.valid | stage0 advancing. It does not depend combinationally on `valid_i`.
- `done_o` = last-stage valid. Output payload is held stable while `done_o`=1 and `ready_i`=0.
- `flush`=1 clears all valid bits at the next edge. An op presented in the flush cycle is dropped. `occupancy_o` becomes 0.
- Reset: all valid bits 0, and all outputs 0: `done_o`, `alu_result`, `cmp_result`, `rd_addr_o`, `rob_index_o`, `occupancy_o`. `ready_o` is 1 after reset.
- Reset takes priority over flush; flush takes priority over accept and advance.

## Timing
- An op accepted at edge N, with no backpressure, has `done_o`=1 from edge N+LATENCY-1 to edge N+LATENCY.
- Throughput is 1 op/cycle with `ready_i` held high.
- Under `ready_i`=0 the pipeline fills to LATENCY ops. `ready_o` drops only when all stages are full.
- Bubbles collapse: an empty intermediate stage is filled even while the output stalls.
- `occupancy_o` updates at each edge: +1 on accept, −1 on output handshake, unchanged on both.

## Configuration
- `ALU_SHADD_EN` defined: adds input `shadd_i[1:0]`. For op ADD_SUB with modifier 0 and half=0, the result is `(a << shadd_i) + b` (Zba sh1add/sh2add/sh3add). `shadd_i`=0 gives a plain ADD.
- `ALU_SHADD_EN` undefined: the port is absent and ADD_SUB behaves as listed above.

## Test plan
- XLEN=64, LATENCY=2: ADD a=5, b=−7 → `alu_result`=0xFFFF_FFFF_FFFF_FFFE, `done_o` 2 cycles after accept, rd/rob echoed.
- W-ops: ADDW a=0x7FFF_FFFF, b=1 → 0xFFFF_FFFF_8000_0000. SRAW a=0x8000_0000, b=4 → 0xFFFF_FFFF_F800_0000.
- Compare: SLTU a=1, b=−1 → 1. cmp_select=0b101 (negated less, signed) with a=−1, b=0 → `cmp_result`=0.
- Backpressure: hold `ready_i`=0 and issue 3 ops with LATENCY=2. The third stalls (`ready_o`=0) and `occupancy_o`=2. On release, results drain in order, one per cycle.
- Flush with 2 in flight plus 1 presented → next cycle `done_o`=0, `occupancy_o`=0, and the presented op never appears.
- Reset asserted mid-stream → all outputs 0 at the next edge and `ready_o`=1. With `ALU_SHADD_EN`: shadd=3, a=2, b=1 → 17.
